uart_tx: RTL

//  Serial UART transmitter: the transmit half of the uart_rx link. Accepts one byte per
//  tx_send handshake and shifts it out on tx as start bit, 8 data bits LSB first,

---
 rtl/uart_pkg.sv | 31 +++
 rtl/uart_baud_cnt.sv | 47 ++++
 rtl/uart_tx.sv | 135 +++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
//------------------------------------------------------------------------------
// Module  : uart_pkg
// Brief   : Shared UART types and constants (state enum, parity modes, timing).
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    localparam int DEFAULT_CLKS_PER_BIT = 868;

    // Even mode makes the total count of ones even; odd mode makes it odd.
    function automatic logic parity_bit(input logic [7:0] b, input int mode);
        return (mode == PAR_ODD) ? ~^b : ^b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_baud_cnt.sv
//------------------------------------------------------------------------------
// Module  : uart_baud_cnt
// Brief   : Bit-period counter, 0..CLKS_PER_BIT-1, with clear and terminal strobe.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module uart_baud_cnt
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clock,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int            W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [W-1:0]  LAST = W'(CLKS_PER_BIT - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign tc_o = en_i && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || tc_o) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_tx.sv
//------------------------------------------------------------------------------
// Module  : uart_tx
// Brief   : UART transmitter: start, 8 data bits LSB first, optional parity, stop.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int PARITY       = PAR_NONE,
    parameter int STOP_BITS    = 1
) (
    input  logic       clock,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_send,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx
);

    if (CLKS_PER_BIT < 2 || PARITY < 0 || PARITY > 2 ||
        (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_bad_params
        $error("uart_tx: illegal CLKS_PER_BIT, PARITY or STOP_BITS");
    end

    uart_state_e state_q, state_d;
    logic [7:0]  shift_q, shift_d;
    logic [2:0]  idx_q, idx_d;
    logic        tx_q, tx_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        w_baud_tc;
    logic        w_idle;

    assign w_idle = (state_q == ST_IDLE);

    uart_baud_cnt #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_cnt (
        .clock (clock),
        .rst   (rst),
        .clr_i (w_idle),
        .en_i  (!w_idle),
        .tc_o  (w_baud_tc)
    );

    // idx counts data bits in DATA and stop bits in STOP.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        unique case (state_q)
            ST_IDLE: begin
                if (tx_send) begin
                    shift_d = tx_data;
                    idx_d   = '0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (w_baud_tc) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_baud_tc) begin
                    if (idx_q == 3'd7) begin
                        idx_d   = '0;
                        state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (w_baud_tc) begin
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (w_baud_tc) begin
                    if (idx_q == 3'(STOP_BITS - 1)) begin
                        idx_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the line level changes on the
    // same edge as the state and comes straight out of a flop.
    always_comb begin
        busy_d = (state_d != ST_IDLE);
        done_d = (state_q == ST_STOP) && (state_d == ST_IDLE);
        tx_d   = 1'b1;
        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_q[idx_d];
            ST_PARITY: tx_d = parity_bit(shift_q, PARITY);
            default:   tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign tx      = tx_q;
    assign tx_busy = busy_q;
    assign tx_done = done_q;

endmodule

`default_nettype wire
